instr_register_ctrl: RTL and testbench

//  Controller sitting in front of instr_register. It shares the register's single load port between two

---
 rtl/instr_register_ctrl_if.sv | 12 +
 rtl/instr_register_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_instr_register_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_register_ctrl_if.sv
// Requester-side load port of instr_register_ctrl: one valid/ready transfer of
// an opcode and two operands per accepted cycle.
interface instr_register_ctrl_if;
   logic               valid;
   logic               ready;
   logic [3:0]         opcode;
   logic signed [31:0] op_a;
   logic signed [31:0] op_b;

   modport master (output valid, output opcode, output op_a, output op_b, input ready);
   modport slave  (input valid, input opcode, input op_a, input op_b, output ready);
endinterface

// File: rtl/instr_register_ctrl.sv
// Round-robin load-port arbiter and in-order queue manager for instr_register.
// Optional macro INSTR_CTRL_DIVZERO_FILTER_EN drops DIV/MOD requests whose op_b is zero.
module instr_register_ctrl #(
   parameter int DEPTH    = 32,
   parameter bit RR_RESET = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   instr_register_ctrl_if.slave      req0,
   instr_register_ctrl_if.slave      req1,
   output logic                      load_en,
   output logic [$clog2(DEPTH)-1:0]  write_pointer,
   output logic [3:0]                opcode,
   output logic signed [31:0]        operand_a,
   output logic signed [31:0]        operand_b,
   output logic [$clog2(DEPTH)-1:0]  read_pointer,
   input  logic [131:0]              instruction_word,
   input  logic                      rd_req,
   output logic                      rd_valid,
   output logic [131:0]              rd_instr,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic                      err_pulse
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] RD_IDLE  = 2'd0;
   localparam logic [1:0] RD_ISSUE = 2'd1;
   localparam logic [1:0] RD_DONE  = 2'd2;

   logic                last_grant_r;
   logic [AW-1:0]       wr_ptr_r;
   logic [AW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;
   logic [1:0]          rd_state_r;
   logic                load_en_r;
   logic [AW-1:0]       write_pointer_r;
   logic [3:0]          opcode_r;
   logic signed [31:0]  operand_a_r;
   logic signed [31:0]  operand_b_r;
   logic [AW-1:0]       read_pointer_r;
   logic                rd_valid_r;
   logic [131:0]        rd_instr_r;
   logic                err_pulse_r;

   logic                grant_s;
   logic                full_s;
   logic                empty_s;
   logic                xfer_s;
   logic                drop_s;
   logic                write_s;
   logic                pop_done_s;
   logic [3:0]          sel_opcode_s;
   logic signed [31:0]  sel_op_a_s;
   logic signed [31:0]  sel_op_b_s;

   assign full_s     = (count_r == FULL_CNT);
   assign empty_s    = (count_r == {CW{1'b0}});
   assign pop_done_s = (rd_state_r == RD_DONE);

   // Round-robin grant: a lone requester wins, contention goes to the one not granted last.
   always_comb begin
      grant_s = 1'b0;
      if (req0.valid && req1.valid) begin
         grant_s = ~last_grant_r;
      end else if (req1.valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Select the granted requester's payload and detect an accepted transfer.
   always_comb begin
      sel_opcode_s = req0.opcode;
      sel_op_a_s   = req0.op_a;
      sel_op_b_s   = req0.op_b;
      xfer_s       = 1'b0;
      if (grant_s) begin
         sel_opcode_s = req1.opcode;
         sel_op_a_s   = req1.op_a;
         sel_op_b_s   = req1.op_b;
         xfer_s       = req1.valid && !full_s;
      end else begin
         sel_opcode_s = req0.opcode;
         sel_op_a_s   = req0.op_a;
         sel_op_b_s   = req0.op_b;
         xfer_s       = req0.valid && !full_s;
      end
   end

   assign req0.ready = !grant_s && !full_s;
   assign req1.ready =  grant_s && !full_s;

`ifdef INSTR_CTRL_DIVZERO_FILTER_EN
   localparam logic [3:0] OPC_DIV = 4'd6;
   localparam logic [3:0] OPC_MOD = 4'd7;

   // Accepted divide-by-zero requests are consumed but never reach the register.
   always_comb begin
      drop_s = 1'b0;
      if (xfer_s && ((sel_opcode_s == OPC_DIV) || (sel_opcode_s == OPC_MOD)) &&
          (sel_op_b_s == 32'sd0)) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end
`else
   assign drop_s = 1'b0;
`endif

   assign write_s = xfer_s && !drop_s;

   // Load port towards instr_register and the write pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_en_r       <= 1'b0;
         write_pointer_r <= {AW{1'b0}};
         opcode_r        <= 4'd0;
         operand_a_r     <= 32'sd0;
         operand_b_r     <= 32'sd0;
         wr_ptr_r        <= {AW{1'b0}};
      end else begin
         load_en_r <= write_s;
         if (write_s) begin
            write_pointer_r <= wr_ptr_r;
            opcode_r        <= sel_opcode_s;
            operand_a_r     <= sel_op_a_s;
            operand_b_r     <= sel_op_b_s;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end else begin
            write_pointer_r <= write_pointer_r;
            opcode_r        <= opcode_r;
            operand_a_r     <= operand_a_r;
            operand_b_r     <= operand_b_r;
            wr_ptr_r        <= wr_ptr_r;
         end
      end
   end

   // Arbitration history and filter error pulse; a dropped request still counts as served.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_r <= RR_RESET;
         err_pulse_r  <= 1'b0;
      end else begin
         err_pulse_r <= drop_s;
         if (xfer_s) begin
            last_grant_r <= grant_s;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Occupancy: an in-flight pop keeps its slot until RD_DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {CW{1'b0}};
      end else begin
         case ({write_s, pop_done_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Three-state pop sequencer: present the pointer, let the register settle, capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_state_r     <= RD_IDLE;
         read_pointer_r <= {AW{1'b0}};
         rd_ptr_r       <= {AW{1'b0}};
         rd_valid_r     <= 1'b0;
         rd_instr_r     <= 132'd0;
      end else begin
         rd_valid_r <= 1'b0;
         case (rd_state_r)
            RD_IDLE: begin
               if (rd_req && !empty_s) begin
                  read_pointer_r <= rd_ptr_r;
                  rd_state_r     <= RD_ISSUE;
               end else begin
                  rd_state_r <= RD_IDLE;
               end
            end
            RD_ISSUE: begin
               rd_state_r <= RD_DONE;
            end
            RD_DONE: begin
               rd_instr_r <= instruction_word;
               rd_valid_r <= 1'b1;
               rd_ptr_r   <= rd_ptr_r + AW'(1);
               rd_state_r <= RD_IDLE;
            end
            default: begin
               rd_state_r <= RD_IDLE;
            end
         endcase
      end
   end

   assign load_en       = load_en_r;
   assign write_pointer = write_pointer_r;
   assign opcode        = opcode_r;
   assign operand_a     = operand_a_r;
   assign operand_b     = operand_b_r;
   assign read_pointer  = read_pointer_r;
   assign rd_valid      = rd_valid_r;
   assign rd_instr      = rd_instr_r;
   assign count         = count_r;
   assign full          = full_s;
   assign empty         = empty_s;
   assign err_pulse     = err_pulse_r;

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl with a behavioural instr_register model.
module tb_instr_register_ctrl;

   localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3,
                          SUB = 4'd4, MULT = 4'd5, DIV = 4'd6, MOD = 4'd7;
`ifdef INSTR_CTRL_DIVZERO_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         load_en;
   logic [4:0]   write_pointer;
   logic [3:0]   opcode;
   logic [31:0]  operand_a;
   logic [31:0]  operand_b;
   logic [4:0]   read_pointer;
   logic [131:0] instruction_word;
   logic         rd_req = 1'b0;
   logic         rd_valid;
   logic [131:0] rd_instr;
   logic [5:0]   count;
   logic         full;
   logic         empty;
   logic         err_pulse;

   int checks = 0;
   int errors = 0;

   logic [131:0] mem [32];
   logic [131:0] sb [$];

   instr_register_ctrl_if req0_bus ();
   instr_register_ctrl_if req1_bus ();

   instr_register_ctrl #(.DEPTH(32), .RR_RESET(1'b1)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req0             (req0_bus),
      .req1             (req1_bus),
      .load_en          (load_en),
      .write_pointer    (write_pointer),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .rd_req           (rd_req),
      .rd_valid         (rd_valid),
      .rd_instr         (rd_instr),
      .count            (count),
      .full             (full),
      .empty            (empty),
      .err_pulse        (err_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] calc(input logic [3:0] opc, input logic [31:0] a,
                                        input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      sa  = 64'($signed(a));
      sb2 = 64'($signed(b));
      case (opc)
         PASSA:   return sa;
         PASSB:   return sb2;
         ADD:     return sa + sb2;
         SUB:     return sa - sb2;
         MULT:    return sa * sb2;
         DIV:     return (sb2 == 64'sd0) ? 64'd0 : sa / sb2;
         MOD:     return (sb2 == 64'sd0) ? 64'd0 : sa % sb2;
         default: return 64'd0;
      endcase
   endfunction

   // instr_register model: synchronous write, combinational read
   always @(posedge clk) begin
      if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b,
                                          calc(opcode, operand_a, operand_b)};
   end
   assign instruction_word = mem[read_pointer];

   typedef struct {
      logic        v0, v1;
      logic [3:0]  opc0, opc1;
      logic [31:0] a0, b0, a1, b1;
      logic        rdy0, rdy1, load;
      logic [4:0]  wp;
      logic [3:0]  opc;
      logic [31:0] a, b;
      logic [5:0]  cnt;
      logic        err;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(input logic v0, input logic [3:0] opc0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic v1, input logic [3:0] opc1,
                               input logic [31:0] a1, input logic [31:0] b1, input logic rdy0,
                               input logic rdy1, input logic load, input logic [4:0] wp,
                               input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] cnt, input logic err);
      vec_t v;
      v.v0 = v0; v.opc0 = opc0; v.a0 = a0; v.b0 = b0;
      v.v1 = v1; v.opc1 = opc1; v.a1 = a1; v.b1 = b1;
      v.rdy0 = rdy0; v.rdy1 = rdy1; v.load = load; v.wp = wp;
      v.opc = opc; v.a = a; v.b = b; v.cnt = cnt; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req0_bus.valid = 1'b0;
      req1_bus.valid = 1'b0;
      rd_req = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      sb.delete();
   endtask

   task automatic do_write(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
      req0_bus.valid  = 1'b1;
      req0_bus.opcode = opc;
      req0_bus.op_a   = a;
      req0_bus.op_b   = b;
      tick();
      req0_bus.valid = 1'b0;
      sb.push_back({opc, a, b, calc(opc, a, b)});
   endtask

   task automatic do_pop(input string name);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      chk({name, "_early"}, rd_valid, 1'b0);
      tick();
      chk({name, "_valid"}, rd_valid, 1'b1);
      chk({name, "_word"}, rd_instr, sb.pop_front());
   endtask

   initial begin
      logic seen;
      req0_bus.valid = 1'b0; req0_bus.opcode = ZERO; req0_bus.op_a = 32'd0; req0_bus.op_b = 32'd0;
      req1_bus.valid = 1'b0; req1_bus.opcode = ZERO; req1_bus.op_a = 32'd0; req1_bus.op_b = 32'd0;

      // reset state
      do_reset();
      chk("rst_load_en", load_en, 1'b0);
      chk("rst_count", count, 6'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_read_pointer", read_pointer, 5'd0);
      chk("rst_write_pointer", write_pointer, 5'd0);
      chk("rst_opcode", opcode, ZERO);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_err", err_pulse, 1'b0);

      // single write and pop
      req0_bus.valid = 1'b1; req0_bus.opcode = ADD; req0_bus.op_a = 32'd5; req0_bus.op_b = 32'd3;
      #1;
      chk("single_ready0", req0_bus.ready, 1'b1);
      tick();
      req0_bus.valid = 1'b0;
      chk("single_load_en", load_en, 1'b1);
      chk("single_wp", write_pointer, 5'd0);
      chk("single_data", {opcode, operand_a, operand_b}, {ADD, 32'd5, 32'd3});
      chk("single_count", count, 6'd1);
      tick();
      chk("single_load_drop", load_en, 1'b0);
      sb.push_back({ADD, 32'd5, 32'd3, 64'd8});
      do_pop("single_pop");
      chk("single_count_after", count, 6'd0);
      tick();
      chk("single_valid_pulse", rd_valid, 1'b0);
      rd_req = 1'b1;
      tick();
      tick();
      tick();
      rd_req = 1'b0;
      chk("empty_pop_ignored", rd_valid, 1'b0);
      chk("empty_pop_count", count, 6'd0);

      // arbitration table
      do_reset();
      for (int i = 0; i < 6; i++) begin
         vecs[i] = mk(1'b1, ADD, 32'(10 + i), 32'(i), 1'b1, SUB, 32'(20 + i), 32'd1,
                      (i % 2) == 0, (i % 2) == 1, 1'b1, 5'(i),
                      ((i % 2) == 0) ? ADD : SUB, ((i % 2) == 0) ? 32'(10 + i) : 32'(20 + i),
                      ((i % 2) == 0) ? 32'(i) : 32'd1, 6'(i + 1), 1'b0);
      end
      vecs[6] = mk(1'b0, ZERO, 32'd0, 32'd0, 1'b1, MULT, 32'd3, 32'd4,
                   1'b0, 1'b1, 1'b1, 5'd6, MULT, 32'd3, 32'd4, 6'd7, 1'b0);
      vecs[7] = mk(1'b0, ZERO, 32'd0, 32'd0, 1'b0, ZERO, 32'd0, 32'd0,
                   1'b1, 1'b0, 1'b0, 5'd6, MULT, 32'd3, 32'd4, 6'd7, 1'b0);
      vecs[8] = FILT ? mk(1'b1, DIV, 32'd9, 32'd0, 1'b0, ZERO, 32'd0, 32'd0,
                          1'b1, 1'b0, 1'b0, 5'd6, MULT, 32'd3, 32'd4, 6'd7, 1'b1)
                     : mk(1'b1, DIV, 32'd9, 32'd0, 1'b0, ZERO, 32'd0, 32'd0,
                          1'b1, 1'b0, 1'b1, 5'd7, DIV, 32'd9, 32'd0, 6'd8, 1'b0);
      vecs[9] = mk(1'b1, MOD, 32'd7, 32'd2, 1'b1, PASSB, 32'd1, 32'd2,
                   1'b0, 1'b1, 1'b1, FILT ? 5'd7 : 5'd8, PASSB, 32'd1, 32'd2,
                   FILT ? 6'd8 : 6'd9, 1'b0);
      for (int i = 0; i < 10; i++) begin
         req0_bus.valid = vecs[i].v0; req0_bus.opcode = vecs[i].opc0;
         req0_bus.op_a = vecs[i].a0;  req0_bus.op_b = vecs[i].b0;
         req1_bus.valid = vecs[i].v1; req1_bus.opcode = vecs[i].opc1;
         req1_bus.op_a = vecs[i].a1;  req1_bus.op_b = vecs[i].b1;
         #1;
         chk($sformatf("vec%0d_ready0", i), req0_bus.ready, vecs[i].rdy0);
         chk($sformatf("vec%0d_ready1", i), req1_bus.ready, vecs[i].rdy1);
         tick();
         chk($sformatf("vec%0d_load_en", i), load_en, vecs[i].load);
         chk($sformatf("vec%0d_wp", i), write_pointer, vecs[i].wp);
         chk($sformatf("vec%0d_data", i), {opcode, operand_a, operand_b},
             {vecs[i].opc, vecs[i].a, vecs[i].b});
         chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
         chk($sformatf("vec%0d_err", i), err_pulse, vecs[i].err);
         if (vecs[i].load)
            sb.push_back({vecs[i].opc, vecs[i].a, vecs[i].b, calc(vecs[i].opc, vecs[i].a, vecs[i].b)});
      end
      req0_bus.valid = 1'b0;
      req1_bus.valid = 1'b0;
      while (sb.size() > 0) do_pop("table_pop");
      chk("table_drain_count", count, 6'd0);
      chk("table_drain_empty", empty, 1'b1);

      // write coinciding with RD_DONE
      do_reset();
      for (int i = 0; i < 5; i++) do_write(ADD, 32'(100 + i), 32'(i));
      chk("sim_count_before", count, 6'd5);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      req0_bus.valid = 1'b1; req0_bus.opcode = PASSA; req0_bus.op_a = 32'd42; req0_bus.op_b = 32'd0;
      tick();
      req0_bus.valid = 1'b0;
      chk("sim_count", count, 6'd5);
      chk("sim_rd_valid", rd_valid, 1'b1);
      chk("sim_load_en", load_en, 1'b1);
      chk("sim_wp", write_pointer, 5'd5);
      chk("sim_word", rd_instr, sb.pop_front());
      sb.push_back({PASSA, 32'd42, 32'd0, calc(PASSA, 32'd42, 32'd0)});
      while (sb.size() > 0) do_pop("order_pop");
      chk("order_count", count, 6'd0);

      // full and pointer wrap
      do_reset();
      for (int i = 0; i < 32; i++) do_write(ADD, 32'(i), 32'd1);
      chk("full_flag", full, 1'b1);
      chk("full_count", count, 6'd32);
      req0_bus.valid = 1'b1; req0_bus.opcode = SUB; req0_bus.op_a = 32'd77; req0_bus.op_b = 32'd7;
      req1_bus.valid = 1'b1; req1_bus.opcode = MULT; req1_bus.op_a = 32'd2; req1_bus.op_b = 32'd2;
      #1;
      chk("full_ready0", req0_bus.ready, 1'b0);
      chk("full_ready1", req1_bus.ready, 1'b0);
      tick();
      chk("full_no_load", load_en, 1'b0);
      chk("full_count_hold", count, 6'd32);
      req1_bus.valid = 1'b0;
      do_pop("full_pop");
      chk("full_freed_count", count, 6'd31);
      chk("full_freed_flag", full, 1'b0);
      chk("full_freed_ready0", req0_bus.ready, 1'b1);
      tick();
      req0_bus.valid = 1'b0;
      chk("wrap_load_en", load_en, 1'b1);
      chk("wrap_wp", write_pointer, 5'd0);
      chk("wrap_count", count, 6'd32);
      chk("wrap_full", full, 1'b1);

      // reset during RD_ISSUE
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_count", count, 6'd0);
      chk("midrst_empty", empty, 1'b1);
      chk("midrst_read_pointer", read_pointer, 5'd0);
      tick();
      tick();
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | rd_valid;
      end
      chk("midrst_no_valid", seen, 1'b0);
      chk("midrst_count_after", count, 6'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
